// File: rtl/vga_pkg.sv
// Shared timing constants, colour width and snapshot FSM encoding for the VGA scan controller.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int COORD_W = 11;
   localparam int COLOR_W = 3;

   typedef enum logic {
      SNAP_IDLE = 1'b0,
      SNAP_REQ  = 1'b1
   } snap_state_e;

   function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus visible-region and sync-window decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = 640,
   parameter int FRONT   = 16,
   parameter int SYNC    = 96,
   parameter int BACK    = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [COORD_W-1:0] count,
   output logic               wrap,
   output logic               visible,
   output logic               in_sync
);

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
   localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

   logic at_last;

   assign at_last = (count == LAST);
   assign wrap    = en && at_last;
   assign visible = (count < COORD_W'(VISIBLE));
   assign in_sync = in_window(count, VISIBLE + FRONT, VISIBLE + FRONT + SYNC - 1);

   // Position counter, advances only when enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (at_last) begin
            count <= '0;
         end else begin
            count <= count + COORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan controller: pixel divider, H/V scan, aligned colour/sync pipeline and
// per-frame snapshot handshake. Optional build macro VGA_BORDER_EN forces a white border.
module vga_scan_controller #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic [vga_pkg::COORD_W-1:0] x,
   output logic [vga_pkg::COORD_W-1:0] y,
   output logic                        pixelTick,
   input  logic [vga_pkg::COLOR_W-1:0] rIn,
   input  logic [vga_pkg::COLOR_W-1:0] gIn,
   input  logic [vga_pkg::COLOR_W-1:0] bIn,
   output logic [vga_pkg::COLOR_W-1:0] r,
   output logic [vga_pkg::COLOR_W-1:0] g,
   output logic [vga_pkg::COLOR_W-1:0] b,
   output logic                        hs,
   output logic                        vs,
   output logic                        snapReq,
   input  logic                        snapAck,
   output logic                        snapOverrun
);
   import vga_pkg::*;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]   div;
   logic [DIV_W-1:0]   div_next;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_vis;
   logic               v_vis;
   logic               h_sync;
   logic               v_sync;
   logic               pix_visible;
   logic               vblank_start;
   logic [COLOR_W-1:0] r_next;
   logic [COLOR_W-1:0] g_next;
   logic [COLOR_W-1:0] b_next;
   snap_state_e        state;
   snap_state_e        state_next;
   logic               overrun_next;
`ifdef VGA_BORDER_EN
   logic               pix_border;
`endif

   // Divider next value; pixelTick is registered so it is clean and low in reset.
   always_comb begin
      if (div == DIV_LAST) begin
         div_next = '0;
      end else begin
         div_next = div + DIV_W'(1);
      end
   end

   // Pixel clock divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div       <= '0;
         pixelTick <= 1'b0;
      end else begin
         div       <= div_next;
         pixelTick <= (div_next == DIV_LAST);
      end
   end

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (pixelTick),
      .count   (x),
      .wrap    (h_wrap),
      .visible (h_vis),
      .in_sync (h_sync)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (h_wrap),
      .count   (y),
      .wrap    (v_wrap),
      .visible (v_vis),
      .in_sync (v_sync)
   );

   assign pix_visible  = h_vis && v_vis;
   assign vblank_start = pixelTick && (x == '0) && (y == COORD_W'(V_VISIBLE));
`ifdef VGA_BORDER_EN
   assign pix_border = (x == '0) || (x == COORD_W'(H_VISIBLE - 1)) ||
                       (y == '0) || (y == COORD_W'(V_VISIBLE - 1));
`endif

   // Colour for the pixel currently addressed; blanked outside the visible area.
   always_comb begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
      if (pix_visible) begin
`ifdef VGA_BORDER_EN
         if (pix_border) begin
            r_next = {COLOR_W{1'b1}};
            g_next = {COLOR_W{1'b1}};
            b_next = {COLOR_W{1'b1}};
         end else begin
            r_next = rIn;
            g_next = gIn;
            b_next = bIn;
         end
`else
         r_next = rIn;
         g_next = gIn;
         b_next = bIn;
`endif
      end else begin
         r_next = '0;
         g_next = '0;
         b_next = '0;
      end
   end

   // Colour and sync share one pipeline stage so they reach the DAC aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r  <= '0;
         g  <= '0;
         b  <= '0;
         hs <= 1'b1;
         vs <= 1'b1;
      end else if (pixelTick) begin
         r  <= r_next;
         g  <= g_next;
         b  <= b_next;
         hs <= !h_sync;
         vs <= !v_sync;
      end
   end

   // Snapshot FSM state and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SNAP_IDLE;
         snapOverrun <= 1'b0;
      end else begin
         state       <= state_next;
         snapOverrun <= overrun_next;
      end
   end

   // Snapshot next state: an ack in REQ wins over a coinciding vblank start.
   always_comb begin
      state_next   = state;
      overrun_next = snapOverrun;
      case (state)
         SNAP_IDLE: begin
            if (vblank_start) begin
               state_next = SNAP_REQ;
            end else begin
               state_next = SNAP_IDLE;
            end
         end
         SNAP_REQ: begin
            if (snapAck) begin
               state_next = SNAP_IDLE;
            end else if (vblank_start) begin
               overrun_next = 1'b1;
            end else begin
               state_next = SNAP_REQ;
            end
         end
         default: begin
            state_next = SNAP_IDLE;
         end
      endcase
   end

   assign snapReq = (state == SNAP_REQ);

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench: a reduced-geometry instance checked pixel by pixel plus a full 640x480 instance for line timing.
module tb_vga_scan_controller;

   localparam int SH_VIS = 8;
   localparam int SH_FR  = 2;
   localparam int SH_SY  = 3;
   localparam int SH_BK  = 3;
   localparam int SV_VIS = 6;
   localparam int SV_FR  = 1;
   localparam int SV_SY  = 2;
   localparam int SV_BK  = 2;
   localparam int SH_TOT = SH_VIS + SH_FR + SH_SY + SH_BK;
   localparam int SV_TOT = SV_VIS + SV_FR + SV_SY + SV_BK;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
      logic       hs;
      logic       vs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        snap_ack;
   logic        col_zero;
   logic [2:0]  r_const;

   logic [10:0] s_x, s_y;
   logic        s_tick, s_hs, s_vs, s_req, s_ovr;
   logic [2:0]  s_rin, s_gin, s_bin, s_r, s_g, s_b;

   logic [10:0] f_x, f_y;
   logic        f_tick, f_hs, f_vs, f_req, f_ovr;
   logic [2:0]  f_rin, f_gin, f_bin, f_r, f_g, f_b;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   assign s_rin = col_zero ? 3'd0 : r_const;
   assign s_gin = col_zero ? 3'd0 : s_x[2:0];
   assign s_bin = col_zero ? 3'd0 : (s_y[2:0] ^ 3'd5);
   assign f_rin = f_x[2:0];
   assign f_gin = f_y[2:0];
   assign f_bin = 3'd1;

   vga_scan_controller #(
      .CLK_DIV(2),
      .H_VISIBLE(SH_VIS), .H_FRONT(SH_FR), .H_SYNC(SH_SY), .H_BACK(SH_BK),
      .V_VISIBLE(SV_VIS), .V_FRONT(SV_FR), .V_SYNC(SV_SY), .V_BACK(SV_BK)
   ) dut (
      .clk(clk), .rst(rst), .x(s_x), .y(s_y), .pixelTick(s_tick),
      .rIn(s_rin), .gIn(s_gin), .bIn(s_bin), .r(s_r), .g(s_g), .b(s_b),
      .hs(s_hs), .vs(s_vs), .snapReq(s_req), .snapAck(snap_ack), .snapOverrun(s_ovr)
   );

   vga_scan_controller dut_full (
      .clk(clk), .rst(rst), .x(f_x), .y(f_y), .pixelTick(f_tick),
      .rIn(f_rin), .gIn(f_gin), .bIn(f_bin), .r(f_r), .g(f_g), .b(f_b),
      .hs(f_hs), .vs(f_vs), .snapReq(f_req), .snapAck(1'b0), .snapOverrun(f_ovr)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Producer: on each pixel tick predict the next registered colour/sync.
   initial begin : producer
      int   mx, my;
      logic vis, brd;
      exp_t e;
      mx = 0;
      my = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mx = 0;
            my = 0;
            exp_q.delete();
         end else if (s_tick) begin
            check("x_pos", int'(s_x), mx);
            check("y_pos", int'(s_y), my);
            vis = (mx < SH_VIS) && (my < SV_VIS);
            brd = (mx == 0) || (mx == SH_VIS - 1) || (my == 0) || (my == SV_VIS - 1);
            e.r = vis ? s_rin : 3'd0;
            e.g = vis ? s_gin : 3'd0;
            e.b = vis ? s_bin : 3'd0;
`ifdef VGA_BORDER_EN
            if (vis && brd) begin
               e.r = 3'd7;
               e.g = 3'd7;
               e.b = 3'd7;
            end
`else
            if (brd && !vis) begin
               e.r = 3'd0;
            end
`endif
            e.hs = !((mx >= SH_VIS + SH_FR) && (mx <= SH_VIS + SH_FR + SH_SY - 1));
            e.vs = !((my >= SV_VIS + SV_FR) && (my <= SV_VIS + SV_FR + SV_SY - 1));
            exp_q.push_back(e);
            if (mx == SH_TOT - 1) begin
               mx = 0;
               my = (my == SV_TOT - 1) ? 0 : my + 1;
            end else begin
               mx = mx + 1;
            end
         end
      end
   end

   // Monitor: after each clock edge compare outputs against the oldest prediction.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pix_r", int'(s_r), int'(e.r));
            check("pix_g", int'(s_g), int'(e.g));
            check("pix_b", int'(s_b), int'(e.b));
            check("pix_hs", int'(s_hs), int'(e.hs));
            check("pix_vs", int'(s_vs), int'(e.vs));
         end
      end
   end

   initial begin : stimulus
      int n, ticks, b2b, maxx, prevx, hs_low, first_low, e0, e1;
      logic prev_tick, done;
      rst = 1'b1;
      snap_ack = 1'b0;
      col_zero = 1'b0;
      r_const = 3'd5;

      repeat (3) @(posedge clk);
      #1;
      check("rst_x", int'(s_x), 0);
      check("rst_y", int'(s_y), 0);
      check("rst_tick", int'(s_tick), 0);
      check("rst_rgb", int'({s_r, s_g, s_b}), 0);
      check("rst_hsvs", int'({s_hs, s_vs}), 3);
      check("rst_snap", int'({s_req, s_ovr}), 0);
      check("rst_full_xy", int'({f_x, f_y}), 0);

      @(posedge clk);
      #3 rst = 1'b0;

      ticks = 0;
      b2b = 0;
      prev_tick = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (s_tick) ticks++;
         if (s_tick && prev_tick) b2b++;
         prev_tick = s_tick;
      end
      check("tick_count_10clk", ticks, 5);
      check("tick_back_to_back", b2b, 0);

      // One full 640x480 line on the default-geometry instance.
      n = 0;
      done = 1'b0;
      maxx = 0;
      prevx = 0;
      hs_low = 0;
      first_low = -1;
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
         if (f_tick) begin
            if (f_y == 11'd1) begin
               done = 1'b1;
               check("line_wrap_x", int'(f_x), 0);
               check("line_prev_x", prevx, 799);
            end else begin
               if (int'(f_x) > maxx) maxx = int'(f_x);
               if (!f_hs) begin
                  hs_low++;
                  if (first_low < 0) first_low = int'(f_x);
               end
               prevx = int'(f_x);
            end
         end
      end
      check("line_done", int'(done), 1);
      check("line_max_x", maxx, 799);
      check("hs_low_ticks", hs_low, 96);
      check("hs_first_low_x", first_low, 657);
      check("overrun_before_rst", int'({s_req, s_ovr}), 3);

      // Asynchronous reset in the middle of the scan.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_xy", int'({s_x, s_y}), 0);
      check("mid_rst_hsvs", int'({s_hs, s_vs}), 3);
      check("mid_rst_rgb", int'({s_r, s_g, s_b}), 0);
      check("mid_rst_snap", int'({s_req, s_ovr}), 0);
      col_zero = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;

      n = 0;
      while (!s_req && n < 600) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("snap_first_clks", n, 194);
      check("snap_first_pos", int'({s_x, s_y}), (1 << 11) + 6);
      check("snap_first_ovr", int'(s_ovr), 0);
      col_zero = 1'b0;
      r_const = 3'd3;

      // Ack coinciding with the next vblank start: ack wins, no overrun.
      n = 0;
      while (!(s_tick && s_x == 11'd0 && s_y == 11'd6) && n < 800) begin
         @(negedge clk);
         n++;
      end
      check("vblank2_found", int'(n < 800), 1);
      snap_ack = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      check("ack_wins_req", int'(s_req), 0);
      check("ack_wins_ovr", int'(s_ovr), 0);
      snap_ack = 1'b0;

      repeat (5) @(negedge clk);
      snap_ack = 1'b1;
      repeat (10) @(negedge clk);
      snap_ack = 1'b0;
      check("ack_ignored_idle", int'(s_req), 0);

      n = 0;
      while (!s_req && n < 800) begin
         @(posedge clk);
         #1;
         n++;
      end
      e1 = cyc;
      check("rereq_period", e1 - e0, 352);
      check("rereq_ovr", int'(s_ovr), 0);

      n = 0;
      while (!s_ovr && n < 800) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("overrun_period", cyc - e1, 352);
      check("overrun_req_held", int'(s_req), 1);

      @(negedge clk);
      snap_ack = 1'b1;
      @(posedge clk);
      #1;
      check("ack_after_ovr_req", int'(s_req), 0);
      check("ack_after_ovr_sticky", int'(s_ovr), 1);
      snap_ack = 1'b0;

      repeat (4) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
